rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Winner selection uses a masked 8:3 priority encoder, giving the same one-hot-to-binary mapping as the team's encoder_83 datapath.
- Holds each grant until the owner signals done, withdraws its request, or a hold timeout expires.
- Sits in front of any shared datapath (bus, encoder, memory port); the grant index drives that datapath's select.

Parameters:
- N, 8, number of requesters; fixed at 8 for this revision.
- IDXW, 3, width of the encoded grant index (log2 N).
- MAX_HOLD, 16, maximum cycles one grant may be held before forced release; legal range 2..255.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request vector; req[k]=1 means requester k wants the resource.
- done  input  1  owner releases the resource this cycle; ignored unless gnt_vld=1.
- gnt  output  8  one-hot grant vector, registered.
- gnt_idx  output  3  binary index of the granted requester, registered.
- gnt_vld  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async, asserted): state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, timeout=0, ptr=3'd0, hold_cnt=0. Outputs clear immediately, without waiting for a clock edge.
- All outputs are registered.

State IDLE:
- If req==0, stay in IDLE; outputs stay 0.
- Otherwise pick the winner w as the first set bit searching ptr, ptr+1, ... wrapping mod 8.
- Next edge: gnt=1<<w, gnt_idx=w, gnt_vld=1, ptr=(w+1) mod 8, hold_cnt=1, state=GRANT.
- Latency: req seen at edge n gives gnt at edge n+1.

State GRANT (owner o = gnt_idx):
- Release occurs when any of these holds: done=1, req[o]=0, or hold_cnt==MAX_HOLD.
- On release, next edge: gnt=0, gnt_vld=0, hold_cnt=0, state=IDLE.
- timeout=1 for that single cycle only when the cause is hold_cnt==MAX_HOLD and neither done nor req-drop is present. done has priority over timeout on the same cycle.
- Otherwise hold_cnt increments and gnt stays stable.
- Requests from other requesters never preempt the current grant.

Fairness and timing rules:
- Minimum one IDLE cycle between consecutive grants (bus turnaround); the gnt_vld gap is exactly 1 cycle when requests stay pending.
- ptr updates only on a new grant, never on release or timeout.
- ptr wraps: winner 7 gives ptr=0.
- A forced-released owner that keeps requesting is served again only after every other pending requester, by the round-robin order.
- done while gnt_vld=0 has no effect.
- Requests that are set and cleared while another grant is held are not remembered; arbitration looks only at req sampled in IDLE.
- Reset mid-grant drops the grant asynchronously. ptr returns to 0 and no timeout pulse is produced.

Decomposition:
- Shared package arb_pkg holds:
  - constants ARB_N=8, ARB_IDXW=3, ARB_MAX_HOLD_DEF=16;
  - state typedef arb_state_t {IDLE, GRANT}.
- Sub-module rr_prio_enc_83, purely combinational:
  - inputs req[7:0] and ptr[2:0];
  - outputs any (1 bit) and idx[2:0];
  - implemented as rotate, lowest-set-bit 8:3 encode, un-rotate.
  - It has its own unit bench against an exhaustive 256x8 reference model.

Test Plan:
1. Assert rst with random req -> gnt=8'h00, gnt_idx=0, gnt_vld=0, timeout=0 asynchronously. Release rst with req=0 -> all outputs stay 0.
2. req=8'h08 at edge n -> gnt=8'h08, gnt_idx=3, gnt_vld=1 at n+1. done=1 at n+3 -> gnt=0, gnt_vld=0 at n+4, and ptr=4 (checked via next arbitration).
3. req=8'hFF held, done pulsed in each grant's first cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0 with exactly one idle cycle between grants.
4. After a grant to 7 (ptr=0), req=8'h81 -> grant 0 first; then, after done, grant 7. Checks wrap-around.
5. MAX_HOLD=16, req=8'h24, no done, ptr=5 -> grant 5 held 16 cycles, then timeout=1 for one cycle and gnt=0. Next grant is requester 2 (search 6,7,0,1,2).
6. Mid-grant async rst pulse between edges -> gnt falls without a clock. After release with req=8'h02 -> grant 1 (ptr=0), gnt_idx=1 one cycle later.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin arbiter.
package arb_pkg;

  localparam int ARB_N            = 8;
  localparam int ARB_IDXW         = 3;
  localparam int ARB_MAX_HOLD_DEF = 16;
  localparam int ARB_CNTW         = 8;   // wide enough for MAX_HOLD up to 255

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Registered grant bundle presented to the shared datapath.
  typedef struct packed {
    logic [ARB_N-1:0]    gnt;
    logic [ARB_IDXW-1:0] idx;
    logic                vld;
  } arb_gnt_t;

  // Lowest-set-bit 8:3 encode; same one-hot-to-binary mapping as encoder_83.
  // Returns 0 for an all-zero input, so callers must qualify with |v.
  function automatic logic [ARB_IDXW-1:0] enc83_lsb(input logic [ARB_N-1:0] v);
    logic [ARB_IDXW-1:0] r;
    r = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (v[i]) r = ARB_IDXW'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_enc_83.sv
// Masked 8:3 priority encoder: first set bit of req searching from ptr upward,
// wrapping mod 8. Built as rotate -> lowest-set-bit encode -> un-rotate.
module rr_prio_enc_83
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]    req,
  input  logic [ARB_IDXW-1:0] ptr,
  output logic                any,
  output logic [ARB_IDXW-1:0] idx
);

  logic [ARB_N-1:0]    rot;
  logic [ARB_IDXW-1:0] rot_idx;

  // Rotate so requester ptr lands on bit 0; 3-bit index add wraps mod 8.
  for (genvar k = 0; k < ARB_N; k++) begin : g_rot
    assign rot[k] = req[ptr + ARB_IDXW'(k)];
  end

  // Encode in rotated space, then undo the rotation.
  always_comb begin
    rot_idx = enc83_lsb(rot);
    any     = |req;
    idx     = rot_idx + ptr;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold-until-done and a hold timeout.
// All outputs are registered; the grant index drives the shared datapath select.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDXW     = ARB_IDXW,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF   // legal range 2..255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  localparam logic [ARB_CNTW-1:0] HOLD_MAX = ARB_CNTW'(MAX_HOLD);

  arb_state_t          state, state_d;
  arb_gnt_t            g_q, g_d;
  logic                to_q, to_d;
  logic [IDXW-1:0]     ptr, ptr_d;
  logic [ARB_CNTW-1:0] hold_cnt, hold_cnt_d;

  logic                win_any;
  logic [IDXW-1:0]     win_idx;
  logic                owner_req;
  logic                at_max;

  rr_prio_enc_83 u_enc (
    .req (req),
    .ptr (ptr),
    .any (win_any),
    .idx (win_idx)
  );

  assign owner_req = req[g_q.idx];
  assign at_max    = (hold_cnt == HOLD_MAX);

  // Next-state and next-output logic; the grant bundle is only rewritten on
  // a new grant or a release, so gnt is stable for the whole hold.
  always_comb begin
    state_d    = state;
    g_d        = g_q;
    to_d       = 1'b0;
    ptr_d      = ptr;
    hold_cnt_d = hold_cnt;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_d    = GRANT;
          g_d.gnt    = N'(1) << win_idx;
          g_d.idx    = win_idx;
          g_d.vld    = 1'b1;
          ptr_d      = win_idx + IDXW'(1);
          hold_cnt_d = ARB_CNTW'(1);
        end
      end
      GRANT: begin
        if (done || !owner_req || at_max) begin
          state_d    = IDLE;
          g_d.gnt    = '0;
          g_d.vld    = 1'b0;
          hold_cnt_d = '0;
          // Only flag a forced release; a voluntary release wins the tie.
          to_d       = at_max && !done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt + ARB_CNTW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        g_d        = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs; async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      g_q      <= '0;
      to_q     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      g_q      <= g_d;
      to_q     <= to_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_cnt_d;
    end
  end

  assign gnt     = g_q.gnt;
  assign gnt_idx = g_q.idx;
  assign gnt_vld = g_q.vld;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed scoreboard bench for rr_arbiter_8: stimulus pushes expected grants
// (index + cycle) and timeout cycles; a negedge monitor pops and compares.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t gq[$];
  int   tq[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic vld_q  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected grant lands on the next rising edge.
  task automatic expect_gnt(input int idx);
    exp_t x;
    x.idx = idx;
    x.cyc = cyc + 1;
    gq.push_back(x);
  endtask

  // Monitor: checks every new grant and every timeout pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot", int'(gnt), gnt_vld ? (1 << gnt_idx) : 0);
      if (gnt_vld && !vld_q) begin
        if (gq.size() == 0) chk("unexpected_grant", int'(gnt_idx), -1);
        else begin
          e = gq.pop_front();
          chk("gnt_idx", int'(gnt_idx), e.idx);
          chk("gnt_cycle", cyc, e.cyc);
        end
      end
      if (timeout) begin
        if (tq.size() == 0) chk("unexpected_timeout", 1, 0);
        else chk("timeout_cycle", cyc, tq.pop_front());
      end
    end
    vld_q <= gnt_vld;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1;
    int c2;

    // 1. async reset with random request, then quiet release
    req = 8'($urandom);
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_vld", int'(gnt_vld), 0);
    chk("rst_timeout", int'(timeout), 0);
    tick(); tick();
    rst = 1'b0; req = 8'h00;
    tick(); tick(); tick();
    chk("idle_vld", int'(gnt_vld), 0);
    chk("idle_gnt", int'(gnt), 0);

    // 2. single request, done on third grant cycle, ptr moves to 4
    req = 8'h08; expect_gnt(3);
    tick(); tick();
    done = 1'b1;
    tick();
    chk("done_release_vld", int'(gnt_vld), 0);
    done = 1'b0; req = 8'h18; expect_gnt(4);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00;
    tick();

    // 3. all requesting, done in first grant cycle -> 0..7,0 with 1-cycle gaps
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 8'hFF;
    c1 = cyc;
    for (int k = 0; k < 9; k++) begin
      exp_t x;
      x.idx = k % 8;
      x.cyc = c1 + 1 + 2 * k;
      gq.push_back(x);
    end
    for (int k = 0; k < 9; k++) begin
      tick(); done = 1'b1;
      tick(); done = 1'b0;
    end
    req = 8'h00;
    tick();

    // 4. grant 7 (ptr wraps to 0), then 8'h81 -> 0 then 7
    req = 8'h80; expect_gnt(7);
    tick(); done = 1'b1;
    tick(); done = 1'b0; req = 8'h81; expect_gnt(0);
    tick(); done = 1'b1;
    tick(); done = 1'b0; expect_gnt(7);
    tick(); done = 1'b1;
    tick(); done = 1'b0; req = 8'h00;
    tick();

    // 5. set ptr=5 via grant 4 released by req drop, then timeout on 8'h24
    req = 8'h10; expect_gnt(4);
    tick(); req = 8'h00;
    tick();
    chk("reqdrop_release_vld", int'(gnt_vld), 0);
    req = 8'h24; expect_gnt(5);
    c1 = cyc;
    tq.push_back(c1 + 17);
    begin
      exp_t x;
      x.idx = 2;
      x.cyc = c1 + 18;
      gq.push_back(x);
    end
    repeat (16) tick();
    chk("hold_16_vld", int'(gnt_vld), 1);
    tick();
    chk("timeout_release_vld", int'(gnt_vld), 0);
    chk("timeout_pulse", int'(timeout), 1);
    tick();
    chk("timeout_single", int'(timeout), 0);
    done = 1'b1;
    tick(); done = 1'b0; req = 8'h00;
    tick();

    // 5b. done on the MAX_HOLD cycle suppresses the timeout pulse (ptr=3 -> 0)
    req = 8'h01; expect_gnt(0);
    c2 = cyc;
    repeat (16) tick();
    chk("hold_max_vld", cyc - c2 == 16 ? int'(gnt_vld) : -1, 1);
    done = 1'b1;
    tick(); done = 1'b0; req = 8'h00;
    chk("done_beats_timeout", int'(timeout), 0);
    chk("done_max_release", int'(gnt_vld), 0);
    tick();

    // done asserted while idle must not block or end the new grant (ptr=1)
    done = 1'b1; req = 8'h02; expect_gnt(1);
    tick(); done = 1'b0;
    tick();
    chk("idle_done_ignored", int'(gnt_vld), 1);
    done = 1'b1;
    tick(); done = 1'b0; req = 8'h00;
    tick();

    // 6. async reset mid-grant, then ptr must be back at 0
    req = 8'h40; expect_gnt(6);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_vld", int'(gnt_vld), 0);
    chk("midrst_timeout", int'(timeout), 0);
    tick(); tick();
    rst = 1'b0; req = 8'h82; expect_gnt(1);
    tick(); tick();
    done = 1'b1;
    tick(); done = 1'b0; req = 8'h00;
    tick(); tick(); tick();

    chk("pending_grants", gq.size(), 0);
    chk("pending_timeouts", tq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
